// File: rtl/mux_pkg.sv
// Shared types and helpers for the N-to-1 TDM mux.
// SCAN support is compiled in only when MUX_SCAN_EN is defined.
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int sel_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux_scan_ptr.sv
// Wrapping channel pointer for SCAN mode (used only when MUX_SCAN_EN is defined).
// Asserting clr together with adv means "this beat used channel 0", so the pointer lands on 1.
module mux_scan_ptr
  import mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  output logic [SEL_W-1:0] ptr
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);
  localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= adv ? ONE : '0;
    end else if (adv) begin
      ptr <= (ptr == LAST) ? '0 : ptr + ONE;
    end
  end

endmodule

// File: rtl/mux_nto1_tdm.sv
// N-to-1 registered mux with manual select or round-robin SCAN and a valid/ready output.
// Define MUX_SCAN_EN to build SCAN support; otherwise mode = 1 behaves as MANUAL.
module mux_nto1_tdm
  import mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 1,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]      s,
  input  logic                  enable,
  input  logic                  mode,
  output logic [WIDTH-1:0]      out,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N_CH);

  state_t           state;
  logic             load;
  logic             scan_req;
  logic [SEL_W-1:0] idx;
  logic             idx_ok;
  logic [WIDTH-1:0] idx_data;

  assign load = !out_valid || out_ready;

`ifdef MUX_SCAN_EN
  logic [SEL_W-1:0] ptr;
  logic             entering;

  assign scan_req = enable && (mode == MODE_SCAN);
  // First beat after entering SCAN always comes from channel 0.
  assign entering = scan_req && (state != SCAN);
  assign idx      = scan_req ? (entering ? '0 : ptr) : s;

  mux_scan_ptr #(.N_CH(N_CH)) u_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load && entering),
    .adv   (load && scan_req),
    .ptr   (ptr)
  );
`else
  // Without SCAN support, mode is read but can never request a scan.
  assign scan_req = 1'b0 & enable & (mode == MODE_SCAN);
  assign idx      = s;
`endif

  assign idx_ok = ({1'b0, idx} < N_LIM);

  always_comb begin
    idx_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (idx == SEL_W'(k)) idx_data = in[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      if (!enable) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end else if (scan_req) begin
        state     <= SCAN;
        out       <= idx_data;
        out_ch    <= idx;
        out_valid <= 1'b1;
      end else begin
        state <= MANUAL;
        if (idx_ok) begin
          out       <= idx_data;
          out_ch    <= idx;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_tdm.sv
// Directed bench: a 4x1-bit instance driven from a vector table, a 3x8-bit instance by hand sequences.
module tb_mux_nto1_tdm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [3:0]  a_in;
  logic [1:0]  a_s;
  logic        a_en, a_mode, a_ready;
  logic        a_out;
  logic [1:0]  a_ch;
  logic        a_valid;

  logic [23:0] b_in;
  logic [1:0]  b_s;
  logic        b_en, b_mode, b_ready;
  logic [7:0]  b_out;
  logic [1:0]  b_ch;
  logic        b_valid;

  int n_vec = 0;
  int n_bad = 0;

  mux_nto1_tdm #(.N_CH(4), .WIDTH(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in(a_in), .s(a_s), .enable(a_en), .mode(a_mode),
    .out(a_out), .out_ch(a_ch), .out_valid(a_valid), .out_ready(a_ready)
  );

  mux_nto1_tdm #(.N_CH(3), .WIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in(b_in), .s(b_s), .enable(b_en), .mode(b_mode),
    .out(b_out), .out_ch(b_ch), .out_valid(b_valid), .out_ready(b_ready)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] in;
    logic [1:0] s;
    logic       en;
    logic       ready;
    logic       e_out;
    logic [1:0] e_ch;
    logic       e_valid;
  } vec_t;

  vec_t vec[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [31:0] g_out, input logic [31:0] e_out,
                       input logic [3:0] g_ch, input logic [3:0] e_ch,
                       input logic g_v, input logic e_v);
    n_vec++;
    if (g_out !== e_out || g_ch !== e_ch || g_v !== e_v) begin
      n_bad++;
      $display("FAIL %s: got out=%h ch=%0d valid=%b, expected out=%h ch=%0d valid=%b",
               name, g_out, g_ch, g_v, e_out, e_ch, e_v);
    end
  endtask

  task automatic check_b(input string name, input logic [7:0] e_out,
                         input logic [1:0] e_ch, input logic e_v);
    check(name, {24'd0, b_out}, {24'd0, e_out}, {2'd0, b_ch}, {2'd0, e_ch}, b_valid, e_v);
  endtask

  logic [7:0] scan_d[5];
  logic [1:0] scan_c[5];

  initial begin
    //           rst   in       s     en    rdy   out   ch    valid
    vec[0]  = '{1'b0, 4'b1111, 2'd3, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
    vec[1]  = '{1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1};
    vec[2]  = '{1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1};
    vec[3]  = '{1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1};
    vec[4]  = '{1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1};
    vec[5]  = '{1'b1, 4'b1110, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1};
    vec[6]  = '{1'b1, 4'b1101, 2'd1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1};
    vec[7]  = '{1'b1, 4'b1011, 2'd2, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1};
    vec[8]  = '{1'b1, 4'b0111, 2'd3, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1};
    vec[9]  = '{1'b1, 4'b1111, 2'd0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0};
    vec[10] = '{1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1};
    vec[11] = '{1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1};
    vec[12] = '{1'b1, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1};
    vec[13] = '{1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1};

    scan_d = '{8'hAA, 8'hBB, 8'hCC, 8'hAA, 8'hBB};
    scan_c = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

    rst_n = 1'b0;
    a_in = '0; a_s = '0; a_en = 1'b0; a_mode = 1'b0; a_ready = 1'b1;
    b_in = '0; b_s = '0; b_en = 1'b0; b_mode = 1'b0; b_ready = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      rst_n   = vec[i].rst_n;
      a_in    = vec[i].in;
      a_s     = vec[i].s;
      a_en    = vec[i].en;
      a_ready = vec[i].ready;
      tick();
      check($sformatf("a_vec%0d", i), {31'd0, a_out}, {31'd0, vec[i].e_out},
            {2'd0, a_ch}, {2'd0, vec[i].e_ch}, a_valid, vec[i].e_valid);
    end

    rst_n = 1'b0; b_in = '1; b_en = 1'b1; b_s = 2'd1;
    tick();
    check_b("b_reset", 8'h00, 2'd0, 1'b0);

    rst_n = 1'b1; b_in = {8'hCC, 8'hBB, 8'hAA}; b_mode = 1'b0;
    tick();
    check_b("b_manual_s1", 8'hBB, 2'd1, 1'b1);
    b_s = 2'd3;
    tick();
    check_b("b_sel_oob", 8'hBB, 2'd1, 1'b0);
    b_en = 1'b0;
    tick();
    check_b("b_disabled", 8'hBB, 2'd1, 1'b0);

    b_en = 1'b1; b_mode = 1'b1; b_s = 2'd2;
    tick();
`ifdef MUX_SCAN_EN
    check_b("b_scan0", scan_d[0], scan_c[0], 1'b1);
    for (int k = 1; k < 5; k++) begin
      tick();
      check_b($sformatf("b_scan%0d", k), scan_d[k], scan_c[k], 1'b1);
    end
    b_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_b($sformatf("b_stall%0d", k), 8'hBB, 2'd1, 1'b1);
    end
    b_ready = 1'b1;
    tick();
    check_b("b_after_stall", 8'hCC, 2'd2, 1'b1);
    tick();
    check_b("b_wrap_again", 8'hAA, 2'd0, 1'b1);
    b_mode = 1'b0; b_s = 2'd1;
    tick();
    check_b("b_to_manual", 8'hBB, 2'd1, 1'b1);
    b_mode = 1'b1;
    tick();
    check_b("b_reenter_scan", 8'hAA, 2'd0, 1'b1);
    tick();
    check_b("b_reenter_next", 8'hBB, 2'd1, 1'b1);
    b_ready = 1'b0;
    tick();
    check_b("b_stall_hold", 8'hBB, 2'd1, 1'b1);
    rst_n = 1'b0;
    tick();
    check_b("b_reset_in_stall", 8'h00, 2'd0, 1'b0);
    rst_n = 1'b1; b_ready = 1'b1;
    tick();
    check_b("b_post_reset", 8'hAA, 2'd0, 1'b1);
`else
    check_b("b_mode1_is_manual", 8'hCC, 2'd2, 1'b1);
    b_s = 2'd0;
    tick();
    check_b("b_mode1_s0", 8'hAA, 2'd0, 1'b1);
    b_ready = 1'b0; b_s = 2'd1;
    tick();
    check_b("b_stall_hold", 8'hAA, 2'd0, 1'b1);
    b_ready = 1'b1;
    tick();
    check_b("b_after_stall", 8'hBB, 2'd1, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_nto1_tdm.md
MUX_NTO1_TDM -- requirements
Module: mux_nto1_tdm

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning the number of input channels (legal range 2..16).
REQ-002 The block SHALL have parameter WIDTH, default 1, meaning bits per channel (legal range 1..32).
REQ-003 The block SHALL have localparam SEL_W, equal to max(1, clog2(N_CH)), meaning the select and channel-index width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port in, input, N_CH*WIDTH bits: channel k occupies in[k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port s, input, SEL_W bits: manual channel select.
REQ-008 The block SHALL have port enable, input, 1 bit: capture permit.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 = MANUAL, 1 = SCAN.
REQ-010 The block SHALL have port out, output, WIDTH bits: registered selected data.
REQ-011 The block SHALL have port out_ch, output, SEL_W bits: channel index of the data on out.
REQ-012 The block SHALL have port out_valid, output, 1 bit: out and out_ch hold an unaccepted beat.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts the beat this cycle.

Function
REQ-014 The block SHALL define load = !out_valid || out_ready; out, out_ch and out_valid SHALL update only when load = 1, and otherwise hold.
REQ-015 The block SHALL implement FSM states IDLE, MANUAL and SCAN, evaluated on each cycle with load = 1: enable = 0 -> IDLE; enable = 1 with mode = 0 -> MANUAL; enable = 1 with mode = 1 -> SCAN.
REQ-016 On a load cycle with enable = 0, the block SHALL set out_valid to 0 and hold out and out_ch at their last values (never X).
REQ-017 In MANUAL, on a load cycle, the block SHALL capture in[s] into out, s into out_ch, and set out_valid to 1; latency from s/in to out is exactly 1 cycle.
REQ-018 In MANUAL, if s >= N_CH, the block SHALL not capture, SHALL set out_valid to 0, and SHALL hold out and out_ch.
REQ-019 In SCAN, on a load cycle, the block SHALL capture in[ptr] into out and ptr into out_ch, set out_valid to 1, and advance ptr; s is ignored.
REQ-020 The pointer ptr SHALL wrap from N_CH-1 to 0, with no gap cycle.
REQ-021 When ptr does not advance (load = 0), a stalled beat SHALL keep its channel; no channel is skipped or repeated across backpressure.
REQ-022 Any entry into SCAN from IDLE or MANUAL SHALL reset ptr to 0 on that same cycle, so the first SCAN beat is channel 0.
REQ-023 A mode or enable change while load = 0 SHALL take effect on the next load cycle; the held beat is unchanged.

Reset
REQ-024 When rst_n = 0 at a clock edge, the block SHALL set out = 0, out_ch = 0, out_valid = 0, ptr = 0 and the FSM to IDLE, regardless of out_ready.
REQ-025 Reset asserted mid-SCAN or mid-stall SHALL discard the pending beat; the first beat after release follows REQ-015..REQ-022.

Configuration
REQ-026 The macro MUX_SCAN_EN SHALL control SCAN support: when defined, SCAN and ptr are compiled in as specified above.
REQ-027 When MUX_SCAN_EN is undefined, the block SHALL omit ptr and the SCAN state, treat mode = 1 as MANUAL, and leave all other behaviour identical.

Structure
REQ-028 Package mux_pkg SHALL hold the FSM state enum (IDLE, MANUAL, SCAN), the mode encodings (MODE_MANUAL = 0, MODE_SCAN = 1) and the SEL_W computation function.
REQ-029 The wrapping pointer SHALL be the single sub-module mux_scan_ptr, with parameter N_CH, inputs clk, rst_n, clr and adv, and output ptr; it is instantiated only under MUX_SCAN_EN.

Verification
REQ-030 Reset check: hold rst_n = 0 with in = all ones and enable = 1 -> out = 0, out_ch = 0, out_valid = 0.
REQ-031 MANUAL one-hot sweep: N_CH = 4, WIDTH = 1, out_ready = 1; apply in = 0001/0010/0100/1000 with s = 0/1/2/3 -> one cycle later out = 1 with out_ch = s; then apply in = 1110/1101/1011/0111 -> out = 0.
REQ-032 SCAN wrap: N_CH = 3, WIDTH = 8, in = {8'hCC, 8'hBB, 8'hAA}, mode = 1, out_ready = 1 -> out sequence AA, BB, CC, AA, BB and out_ch sequence 0, 1, 2, 0, 1.
REQ-033 Backpressure: in SCAN, drop out_ready for 3 cycles while out_ch = 1 -> out and out_ch hold at 1 with out_valid = 1; after release the next beat is channel 2, with no skip.
REQ-034 Boundary: N_CH = 3, MANUAL, s = 3 -> out_valid = 0 and out held; then enable = 0 -> out_valid = 0 and out not X.
REQ-035 Configuration: build without MUX_SCAN_EN, apply mode = 1, s = 2 -> behaviour is MANUAL, with out = in[2] and out_ch = 2.
